vic20_prg_loader: RTL and testbench

Download-side loader between the SPI data_io byte stream and the shared memory write port (SDRAM / internal RAM mux) of the VIC-20 core. It parses PRG and CRT images, turns each payload byte into an addressed write, and buffers writes in a small FIFO so the slow memory handshake never stalls the stream. After a PRG ends, it injects the BASIC end-of-program pointers into zero page so `RUN` works immediately.

---
 rtl/vic20_loader_pkg.sv | 41 ++++
 rtl/loader_fifo.sv | 69 ++++++
 rtl/vic20_prg_loader.sv | 190 +++++++++++++++++++
 tb/tb_vic20_prg_loader.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vic20_loader_pkg.sv
// Shared states, constants and write payload type for the VIC-20 PRG/CRT download loader.
package vic20_loader_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned INJ_N  = 8;

  localparam logic [4:0] IDX_PRG = 5'd1;
  localparam logic [4:0] IDX_CRT = 5'd2;

  typedef enum logic [2:0] {
    IDLE,
    HDR_LO,
    HDR_HI,
    DATA,
    DRAIN,
    INJECT,
    DONE
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_wr_t;

  // BASIC zero-page pointers (VARTAB, ARYTAB, STREND, end of load), sent as lo/hi pairs
  function automatic logic [ADDR_W-1:0] inj_addr(input logic [2:0] idx);
    case (idx)
      3'd0: inj_addr = 16'h002D;
      3'd1: inj_addr = 16'h002E;
      3'd2: inj_addr = 16'h002F;
      3'd3: inj_addr = 16'h0030;
      3'd4: inj_addr = 16'h0031;
      3'd5: inj_addr = 16'h0032;
      3'd6: inj_addr = 16'h00AE;
      3'd7: inj_addr = 16'h00AF;
      default: inj_addr = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/loader_fifo.sv
// Write buffer between the download stream and the memory handshake.
// Head entry is registered and presented whenever the FIFO is not empty.
module loader_fifo
  import vic20_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk_sys,
  input  logic    reset,
  input  logic    push,
  input  mem_wr_t push_data,
  input  logic    pop,
  output mem_wr_t head,
  output logic    valid,
  output logic    empty,
  output logic    full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  mem_wr_t       mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_n;
  logic [CW-1:0] count_q, count_n;
  logic          push_ok, pop_ok;

  // A push on a full FIFO is only taken when the head leaves in the same cycle
  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    rd_ptr_n = rd_ptr_q + AW'(pop_ok);
    count_n  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk_sys) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head     <= mem_wr_t'(0);
      valid    <= 1'b0;
      empty    <= 1'b1;
      full     <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      rd_ptr_q <= rd_ptr_n;
      count_q  <= count_n;
      if (count_n == '0) begin
        head <= mem_wr_t'(0);
      end else if (push_ok && (rd_ptr_n == wr_ptr_q)) begin
        head <= push_data;
      end else begin
        head <= mem_q[rd_ptr_n];
      end
      valid <= (count_n != '0);
      empty <= (count_n == '0);
      full  <= (count_n == CW'(DEPTH));
    end
  end

endmodule

// File: rtl/vic20_prg_loader.sv
// PRG/CRT download loader: turns data_io bytes into buffered memory writes.
// Define VIC20_PRG_PTR_INJECT_EN to write the BASIC end pointers after a PRG.
module vic20_prg_loader
  import vic20_loader_pkg::*;
#(
  parameter logic [15:0] CRT_DEFAULT_ADDR = 16'hA000,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        dl_active,
  input  logic [7:0]  dl_index,
  input  logic        dl_wr,
  input  logic [15:0] dl_addr,
  input  logic [7:0]  dl_data,
  input  logic        crt_hdr,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  input  logic        mem_ack,
  output logic        busy,
  output logic        overflow,
  output logic [15:0] end_addr
);

  localparam int unsigned INJ_W = 4;

  state_t           state_q, state_d;
  logic [15:0]      load_q, load_d;
  logic [15:0]      count_q, count_d;
  logic [15:0]      end_addr_q, end_addr_d;
  logic             is_prg_q, is_prg_d;
  logic             overflow_q, overflow_d;
  logic [INJ_W-1:0] inj_idx_q, inj_idx_d;
  logic             push, pop;
  mem_wr_t          push_data, head;
  logic             fifo_valid, fifo_empty, fifo_full;
  logic [4:0]       idx;

  assign idx = dl_index[4:0];
  assign pop = mem_ack && fifo_valid;

  loader_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .valid     (fifo_valid),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Next-state and job bookkeeping
  always_comb begin
    state_d    = state_q;
    load_d     = load_q;
    count_d    = count_q;
    end_addr_d = end_addr_q;
    is_prg_d   = is_prg_q;
    overflow_d = overflow_q;
    inj_idx_d  = inj_idx_q;
    push       = 1'b0;
    push_data  = mem_wr_t'(0);

    unique case (state_q)
      IDLE: begin
        if (dl_active && ((idx == IDX_PRG) || (idx == IDX_CRT))) begin
          is_prg_d   = (idx == IDX_PRG);
          count_d    = '0;
          overflow_d = 1'b0;
          if ((idx == IDX_PRG) || crt_hdr) begin
            state_d = HDR_LO;
          end else begin
            load_d  = CRT_DEFAULT_ADDR;
            state_d = DATA;
          end
        end
      end
      HDR_LO: begin
        if (dl_wr) begin
          load_d[7:0] = dl_data;
          state_d     = HDR_HI;
        end
      end
      HDR_HI: begin
        if (dl_wr) begin
          load_d[15:8] = dl_data;
          state_d      = DATA;
        end
      end
      DATA: begin
        if (dl_wr) begin
          if (fifo_full && !pop) begin
            overflow_d = 1'b1;
          end else begin
            push           = 1'b1;
            push_data.addr = load_q + count_q;
            push_data.data = dl_data;
          end
          count_d = count_q + 16'd1;
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
`ifdef VIC20_PRG_PTR_INJECT_EN
          inj_idx_d = '0;
          state_d   = is_prg_q ? INJECT : DONE;
`else
          state_d   = DONE;
`endif
        end
      end
      INJECT: begin
        // One pointer write outstanding at a time: queue the next only once the last has left
        if (fifo_empty) begin
          if (inj_idx_q == INJ_W'(INJ_N)) begin
            state_d = DONE;
          end else begin
            push           = 1'b1;
            push_data.addr = inj_addr(inj_idx_q[2:0]);
            push_data.data = inj_idx_q[0] ? end_addr_q[15:8] : end_addr_q[7:0];
            inj_idx_d      = inj_idx_q + INJ_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (dl_wr && (state_q inside {DRAIN, INJECT, DONE})) begin
      overflow_d = 1'b1;
    end

    // End of stream: a byte in the same cycle has already been taken above
    if (!dl_active && (state_q inside {HDR_LO, HDR_HI, DATA})) begin
      if (state_d == DATA) begin
        state_d    = DRAIN;
        end_addr_d = load_d + count_d;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      load_q     <= '0;
      count_q    <= '0;
      end_addr_q <= '0;
      is_prg_q   <= 1'b0;
      overflow_q <= 1'b0;
      inj_idx_q  <= '0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_q     <= load_d;
      count_q    <= count_d;
      end_addr_q <= end_addr_d;
      is_prg_q   <= is_prg_d;
      overflow_q <= overflow_d;
      inj_idx_q  <= inj_idx_d;
      busy       <= (state_d != IDLE);
    end
  end

  assign mem_req  = fifo_valid;
  assign mem_addr = head.addr;
  assign mem_data = head.data;
  assign overflow = overflow_q;
  assign end_addr = end_addr_q;

  // File offsets and the upper index bits carry nothing the loader needs
`ifdef VIC20_PRG_PTR_INJECT_EN
  logic unused_bits;
  assign unused_bits = ^{dl_index[7:5], dl_addr};
`else
  logic unused_bits;
  assign unused_bits = ^{dl_index[7:5], dl_addr, is_prg_q};
`endif

endmodule

// File: tb/tb_vic20_prg_loader.sv
// Directed bench for vic20_prg_loader: expected write lists come from a file-level model of the loader.
module tb_vic20_prg_loader;

  localparam logic [15:0] CRT_DEF = 16'hA000;
  localparam int          DEPTH   = 4;
  localparam int          GAP     = 8;
  localparam int          ACK_DLY = 3;
`ifdef VIC20_PRG_PTR_INJECT_EN
  localparam int INJ_N = 8;
`else
  localparam int INJ_N = 0;
`endif

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        clk_sys = 1'b0;
  logic        reset, dl_active, dl_wr, crt_hdr, mem_ack;
  logic [7:0]  dl_index, dl_data, mem_data;
  logic [15:0] dl_addr, mem_addr, end_addr;
  logic        mem_req, busy, overflow;

  int          checks = 0;
  int          errors = 0;
  int          hs_count = 0;
  logic        ack_en;
  wr_t         exp_q[$];
  logic [7:0]  fb [16];
  logic [15:0] zp [8] = '{16'h002D, 16'h002E, 16'h002F, 16'h0030,
                          16'h0031, 16'h0032, 16'h00AE, 16'h00AF};
  logic [15:0] e_end;
  logic        e_ovf;
  int          hs0, hs1;

  vic20_prg_loader #(
    .CRT_DEFAULT_ADDR (CRT_DEF),
    .FIFO_DEPTH       (DEPTH)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .dl_active (dl_active),
    .dl_index  (dl_index),
    .dl_wr     (dl_wr),
    .dl_addr   (dl_addr),
    .dl_data   (dl_data),
    .crt_hdr   (crt_hdr),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .overflow  (overflow),
    .end_addr  (end_addr)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  // Expected writes for one image: payload bytes at load+k (mod 2^16), then the pointer pairs for a PRG
  task automatic model_dl(input logic is_prg, input logic hdr, input int n, input logic blocked,
                          output logic [15:0] end_o, output logic ovf_o);
    logic [15:0] load;
    int first, npay, kept;
    if (is_prg || hdr) begin
      load  = {fb[1], fb[0]};
      first = 2;
    end else begin
      load  = CRT_DEF;
      first = 0;
    end
    npay = n - first;
    kept = (blocked && npay > DEPTH) ? DEPTH : npay;
    for (int k = 0; k < kept; k++) exp_q.push_back({16'(load + 16'(k)), fb[first + k]});
    end_o = 16'(load + 16'(npay));
    ovf_o = (npay > kept);
`ifdef VIC20_PRG_PTR_INJECT_EN
    if (is_prg) begin
      for (int j = 0; j < 8; j++) exp_q.push_back({zp[j], (j % 2 == 1) ? end_o[15:8] : end_o[7:0]});
    end
`endif
  endtask

  task automatic set_file(input logic [7:0] b0, b1, b2, b3, b4, b5);
    fb[0] = b0; fb[1] = b1; fb[2] = b2; fb[3] = b3; fb[4] = b4; fb[5] = b5;
  endtask

  task automatic start_dl(input logic [7:0] index, input logic hdr);
    @(posedge clk_sys); #1;
    dl_index  = index;
    crt_hdr   = hdr;
    dl_active = 1'b1;
    repeat (2) @(posedge clk_sys);
  endtask

  task automatic send_bytes(input int n, input int first_pay);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys); #1;
      dl_wr   = 1'b1;
      dl_addr = 16'(i);
      dl_data = fb[i];
      @(posedge clk_sys); #1;
      dl_wr = 1'b0;
      if (i == first_pay) begin
        @(negedge clk_sys);
        chk("first_byte_latency_req", mem_req, 1'b1);
      end
      repeat (GAP) @(posedge clk_sys);
    end
  endtask

  task automatic end_dl();
    @(posedge clk_sys); #1;
    dl_active = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int c;
    for (c = 0; c < 400; c++) begin
      @(negedge clk_sys);
      if (!busy) break;
    end
    if (c == 400) chk({nm, "_idle_timeout"}, busy, 1'b0);
  endtask

  task automatic post_check(input string nm, input logic [15:0] lit_end, input int lit_hs, input logic lit_ovf);
    chk({nm, "_end_addr_model"}, end_addr, e_end);
    chk({nm, "_end_addr_lit"}, end_addr, lit_end);
    chk({nm, "_overflow"}, overflow, e_ovf);
    chk({nm, "_overflow_lit"}, overflow, lit_ovf);
    chk({nm, "_writes_left"}, exp_q.size(), 0);
    chk({nm, "_write_count"}, hs_count - hs0, lit_hs);
    chk({nm, "_req_idle"}, mem_req, 1'b0);
  endtask

  // Memory side: acknowledge each request ACK_DLY cycles after it is seen
  initial begin
    forever begin
      @(negedge clk_sys);
      if (ack_en && mem_req && !mem_ack) begin
        repeat (ACK_DLY) @(posedge clk_sys);
        #1 mem_ack = 1'b1;
        @(posedge clk_sys);
        #1 mem_ack = 1'b0;
      end
    end
  end

  // Compare every accepted write against the model, and check the request is held until accepted
  initial begin
    logic        prev_req, prev_ack;
    logic [15:0] prev_addr;
    logic [7:0]  prev_data;
    wr_t         e;
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0; prev_data = '0;
    forever begin
      @(negedge clk_sys);
      if (!reset) begin
        if (prev_req && !prev_ack && mem_req) begin
          chk("hold_addr", mem_addr, prev_addr);
          chk("hold_data", mem_data, prev_data);
        end
        if (mem_req && mem_ack) begin
          hs_count++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual=%h:%h required=none", mem_addr, mem_data);
          end else begin
            e = exp_q.pop_front();
            chk("write_addr", mem_addr, e.a);
            chk("write_data", mem_data, e.d);
          end
        end
      end
      prev_req  = mem_req && !reset;
      prev_ack  = mem_ack;
      prev_addr = mem_addr;
      prev_data = mem_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; dl_active = 1'b0; dl_index = '0; dl_wr = 1'b0; dl_addr = '0;
    dl_data = '0; crt_hdr = 1'b0; mem_ack = 1'b0; ack_en = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;
    @(negedge clk_sys);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_data", mem_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_end_addr", end_addr, 16'h0000);

    // Unsupported image type is ignored
    @(posedge clk_sys); #1;
    dl_index = 8'h03; dl_active = 1'b1;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("bad_index_busy", busy, 1'b0);
    end_dl();

    // PRG 01 10 AA BB CC
    set_file(8'h01, 8'h10, 8'hAA, 8'hBB, 8'hCC, 8'h00);
    model_dl(1'b1, 1'b0, 5, 1'b0, e_end, e_ovf);
    chk("model_pin_first", exp_q[0], {16'h1001, 8'hAA});
    chk("model_pin_third", exp_q[2], {16'h1003, 8'hCC});
`ifdef VIC20_PRG_PTR_INJECT_EN
    chk("model_pin_inj_lo", exp_q[3], {16'h002D, 8'h04});
    chk("model_pin_inj_last", exp_q[10], {16'h00AF, 8'h10});
`endif
    hs0 = hs_count;
    start_dl(8'h01, 1'b0);
    send_bytes(5, 2);
    end_dl();
    wait_idle("prg");
    post_check("prg", 16'h1004, 3 + INJ_N, 1'b0);

    // CRT without header
    set_file(8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00);
    model_dl(1'b0, 1'b0, 3, 1'b0, e_end, e_ovf);
    chk("model_pin_crt", exp_q[0], {16'hA000, 8'h11});
    hs0 = hs_count;
    start_dl(8'h02, 1'b0);
    send_bytes(3, 0);
    end_dl();
    wait_idle("crt0");
    post_check("crt0", 16'hA003, 3, 1'b0);

    // CRT with header 00 60
    set_file(8'h00, 8'h60, 8'h5A, 8'hA5, 8'h00, 8'h00);
    model_dl(1'b0, 1'b1, 4, 1'b0, e_end, e_ovf);
    chk("model_pin_crt1", exp_q[0], {16'h6000, 8'h5A});
    hs0 = hs_count;
    start_dl(8'h02, 1'b1);
    send_bytes(4, 2);
    end_dl();
    wait_idle("crt1");
    post_check("crt1", 16'h6002, 2, 1'b0);

    // Overflow: memory stalled while 6 bytes arrive
    set_file(8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5);
    model_dl(1'b0, 1'b0, 6, 1'b1, e_end, e_ovf);
    ack_en = 1'b0;
    hs0 = hs_count;
    start_dl(8'h02, 1'b0);
    send_bytes(6, 0);
    @(negedge clk_sys);
    chk("ovf_live_flag", overflow, 1'b1);
    chk("ovf_live_no_writes", hs_count - hs0, 0);
    ack_en = 1'b1;
    end_dl();
    wait_idle("ovf");
    post_check("ovf", 16'hA006, 4, 1'b1);

    // PRG at $FFFF wraps; upper index bits ignored
    set_file(8'hFF, 8'hFF, 8'h12, 8'h34, 8'h00, 8'h00);
    model_dl(1'b1, 1'b0, 4, 1'b0, e_end, e_ovf);
    chk("model_pin_wrap", exp_q[1], {16'h0000, 8'h34});
    hs0 = hs_count;
    start_dl(8'hE1, 1'b0);
    send_bytes(4, 2);
    end_dl();
    wait_idle("wrap");
    post_check("wrap", 16'h0001, 2 + INJ_N, 1'b0);

    // Header-only PRG
    set_file(8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00);
    model_dl(1'b1, 1'b0, 2, 1'b0, e_end, e_ovf);
    hs0 = hs_count;
    start_dl(8'h01, 1'b0);
    send_bytes(2, 2);
    end_dl();
    wait_idle("hdronly");
    post_check("hdronly", 16'h2000, INJ_N, 1'b0);

    // Reset in the middle of a job abandons it
    set_file(8'h00, 8'h30, 8'h01, 8'h02, 8'h03, 8'h00);
`ifdef VIC20_PRG_PTR_INJECT_EN
    model_dl(1'b1, 1'b0, 4, 1'b0, e_end, e_ovf);
    hs0 = hs_count;
    start_dl(8'h01, 1'b0);
    send_bytes(4, 2);
    end_dl();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_sys); #1;
      if (hs_count - hs0 >= 5) break;
    end
    chk("rst_mid_progress", hs_count - hs0, 5);
    @(posedge clk_sys); #1;
    reset = 1'b1;
`else
    ack_en = 1'b0;
    start_dl(8'h01, 1'b0);
    send_bytes(5, 2);
    @(posedge clk_sys); #1;
    reset = 1'b1;
    dl_active = 1'b0;
`endif
    @(posedge clk_sys); #1;
    reset = 1'b0;
    @(negedge clk_sys);
    chk("rst_mid_req", mem_req, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_end_addr", end_addr, 16'h0000);
    exp_q.delete();
    ack_en = 1'b1;
    hs1 = hs_count;
    repeat (40) @(negedge clk_sys);
    chk("rst_mid_no_writes", hs_count - hs1, 0);
    chk("rst_mid_req_quiet", mem_req, 1'b0);

    // Loader recovers after reset
    set_file(8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    model_dl(1'b0, 1'b0, 1, 1'b0, e_end, e_ovf);
    hs0 = hs_count;
    start_dl(8'h02, 1'b0);
    send_bytes(1, 0);
    end_dl();
    wait_idle("recover");
    post_check("recover", 16'hA001, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
